k2_fetch_unit: RTL
==================

Name: k2_fetch_unit

Overview:
Instruction-fetch stage of the k2 8-bit core, directly upstream of the combinational instruction memory.
- Owns the program counter and drives the imem address.
- Captures the returned instruction into a single-entry instruction register.
- Hands the instruction to the decoder over a valid/ready handshake.
- Supports jump redirect with flush, halt, and resume.

Parameters:
ADDR_W, 4, program counter / imem address width
INST_W, 8, instruction width

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  ADDR_W  fetch address to instruction memory, equals pc register
imem_inst  in  INST_W  instruction returned combinationally for imem_addr
redirect_valid  in  1  jump/branch taken this cycle
redirect_target  in  ADDR_W  new fetch address when redirect_valid=1
halt_req  in  1  stop fetching, level-sensitive
out_valid  out  1  out_inst/out_pc hold a valid instruction
out_ready  in  1  decoder accepts the instruction this cycle
out_inst  out  INST_W  fetched instruction
out_pc  out  ADDR_W  address out_inst was fetched from
halted  out  1  fetch stopped and output buffer empty

Behaviour:
- Reset values: pc=0, out_valid=0, out_inst=0, out_pc=0, halted=0, state=RUN. Reset has priority over every other input.
- imem_addr = pc register, combinational, no extra logic in the path.
- States:
  - RUN: normal fetch.
  - DRAIN: halt seen, waiting for the buffer to empty.
  - HALTED: idle.
- The buffer is free when out_valid=0 or out_ready=1 (a transfer occurs this cycle).
- RUN, priority order:
  1. redirect_valid: pc<=redirect_target, out_valid<=0 (flush; an accepted transfer this cycle still counts).
  2. halt_req: no new fetch, pc unchanged. If the buffer is free: out_valid<=0, go to HALTED. Otherwise go to DRAIN.
  3. Buffer free: out_inst<=imem_inst, out_pc<=pc, out_valid<=1, pc<=pc+1.
  4. Otherwise: hold all registers (stall).
- DRAIN:
  - redirect_valid: flush and go to RUN with pc<=target.
  - Else when out_ready=1: out_valid<=0, go to HALTED.
- HALTED:
  - halted=1, out_valid=0.
  - redirect_valid: pc<=target, go to RUN.
  - halt_req is ignored; deasserting halt_req alone does not resume.
- Latency:
  - After reset deassertion, out_valid=1 with out_pc=0 one cycle later.
  - Redirect in cycle c: cycle c+1 shows out_valid=0 and imem_addr=target. Cycle c+2 shows out_valid=1 and out_pc=target.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 15 wraps to 0 with no flag.
- Stability: out_inst/out_pc must not change while out_valid=1 and out_ready=0, except on flush or reset.
- Simultaneous redirect and halt_req: redirect wins and halt_req is re-evaluated next cycle.

Decomposition:
- Shared package k2_pkg holds:
  - ADDR_W and INST_W constants
  - addr_t and inst_t typedefs
  - fetch_state_t enum {RUN, DRAIN, HALTED}
  - IDLE_INST constant 8'b00110000, used by benches for padding checks
- One natural sub-module, k2_pc_reg: pc register with synchronous reset, load (redirect) and increment enable, with wrap.
- State machine and instruction register live in k2_fetch_unit.

Test Plan:
- Reset then out_ready=1 constantly, imem modelled as inst=addr+8'h10 -> out_pc sequence 0,1,2,… from cycle 1, out_inst=8'h10,8'h11,…, one per cycle.
- out_ready=0 for 3 cycles while out_valid=1 at out_pc=5 -> out_inst/out_pc frozen, imem_addr=6 held; on release, 5 transfers, then 6 next cycle.
- Free-run past address 15 -> out_pc 14,15,0,1 with no bubble.
- redirect_valid=1, target=9 while stalled at out_pc=3 -> next cycle out_valid=0 and imem_addr=9; cycle after, out_valid=1 and out_pc=9.
- halt_req=1 with out_valid=1, out_ready=0 -> DRAIN, then halted=1 the cycle after out_ready=1. Later redirect target=2 -> halted=0 and out_pc=2 two cycles later.
- Reset asserted mid-stream at out_pc=7 -> next cycle all outputs at reset values and imem_addr=0; fetch restarts at 0.

Source files
------------

// File: rtl/k2_pkg.sv
// Shared types and constants for the k2 8-bit core front end.
package k2_pkg;

    localparam int ADDR_W = 4;
    localparam int INST_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam inst_t IDLE_INST = 8'b0011_0000;

endpackage

// File: rtl/k2_pc_reg.sv
// Program counter with synchronous reset, redirect load and wrapping increment.
module k2_pc_reg
    import k2_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [ADDR_W_P-1:0] target_i,
    input  logic                inc_i,
    output logic [ADDR_W_P-1:0] pc_o
);

    logic [ADDR_W_P-1:0] pc_q;
    logic [ADDR_W_P-1:0] pc_d;

    // Load beats increment; the add wraps naturally at the register width.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/k2_fetch_unit.sv
// Fetch stage: drives imem from the pc and buffers one instruction for the decoder.
module k2_fetch_unit
    import k2_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int INST_W_P = INST_W
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W_P-1:0] imem_addr,
    input  logic [INST_W_P-1:0] imem_inst,
    input  logic                redirect_valid,
    input  logic [ADDR_W_P-1:0] redirect_target,
    input  logic                halt_req,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INST_W_P-1:0] out_inst,
    output logic [ADDR_W_P-1:0] out_pc,
    output logic                halted
);

    fetch_state_t        state_q, state_d;
    logic                valid_q, valid_d;
    logic [INST_W_P-1:0] inst_q, inst_d;
    logic [ADDR_W_P-1:0] opc_q, opc_d;
    logic [ADDR_W_P-1:0] pc;
    logic                pcLoad;
    logic                pcInc;
    logic                bufFree;

    k2_pc_reg #(.ADDR_W_P(ADDR_W_P)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load_i   (pcLoad),
        .target_i (redirect_target),
        .inc_i    (pcInc),
        .pc_o     (pc)
    );

    // A transfer happening this cycle frees the buffer for a same-cycle refill.
    assign bufFree = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        pcLoad  = 1'b0;
        pcInc   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pcLoad  = 1'b1;
                    valid_d = 1'b0;
                end else if (halt_req) begin
                    if (bufFree) begin
                        valid_d = 1'b0;
                        state_d = HALTED;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bufFree) begin
                    inst_d  = imem_inst;
                    opc_d   = pc;
                    valid_d = 1'b1;
                    pcInc   = 1'b1;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pcLoad  = 1'b1;
                    valid_d = 1'b0;
                    state_d = RUN;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = HALTED;
                end
            end
            HALTED: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pcLoad  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            valid_q <= 1'b0;
            inst_q  <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
        end
    end

    assign imem_addr = pc;
    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_pc    = opc_q;
    assign halted    = (state_q == HALTED);

endmodule
